// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/overflow manager for the async FIFO.
// Optional wr_level output port is enabled by defining ASYNC_FIFO_WR_LEVEL_EN.
module async_fifo_wptr_full #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    input  logic              ovf_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    ,
    output logic [ADDR_W:0]   wr_level
`endif
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    // Gray pattern of a pointer exactly one depth ahead: top two bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W - 1);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level_next;
    logic             full_next;
    logic             afull_next;
    logic             ovf_next;

    // Write strobe is qualified by the registered full flag only.
    assign wr_en = wr_req & ~full;
    assign waddr = wbin[ADDR_W-1:0];

    // Next-pointer, Gray encode and fill-level computation.
    always_comb begin
        wbin_next  = wbin + PTR_W'(wr_en);
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            rbin[i] = ^(rptr_gray_sync >> i);
        end
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == (rptr_gray_sync ^ FULL_MASK));
        afull_next = (level_next >= PTR_W'(AFULL_THRESH));
        ovf_next   = overflow;
        if (wr_req && full) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= full_next;
            almost_full <= afull_next;
            overflow    <= ovf_next;
        end
    end

`ifdef ASYNC_FIFO_WR_LEVEL_EN
    // Registered fill level exported for observability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_level <= '0;
        end else begin
            wr_level <= level_next;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Scoreboard bench for async_fifo_wptr_full (ADDR_W=4, AFULL_THRESH=12).
// Honours ASYNC_FIFO_WR_LEVEL_EN for the optional wr_level port.
module tb_async_fifo_wptr_full;

    localparam int DEPTH  = 16;
    localparam int THRESH = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_req;
    logic [4:0] rptr_gray_sync;
    logic       ovf_clr;
    logic       wr_en;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic       overflow;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    logic [4:0] wr_level;
`endif

    async_fifo_wptr_full #(.ADDR_W(4), .AFULL_THRESH(12)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_req         (wr_req),
        .rptr_gray_sync (rptr_gray_sync),
        .ovf_clr        (ovf_clr),
        .wr_en          (wr_en),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow)
`ifdef ASYNC_FIFO_WR_LEVEL_EN
        ,
        .wr_level       (wr_level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic       ovf;
        logic [4:0] level;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model: plain write/read counts and sticky flags.
    int wcnt = 0;
    int rcnt = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    // Drive one cycle of stimulus and push the expected response.
    task automatic step(input bit req, input bit clr, input bit rinc);
        exp_t e;
        int   lvl;
        @(negedge clk);
        if (rinc && rcnt < wcnt) rcnt++;
        wr_req         = req;
        ovf_clr        = clr;
        rptr_gray_sync = to_gray(rcnt);
        e.wr_en = req && !m_full;
        if (req && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (e.wr_en) wcnt++;
        lvl    = wcnt - rcnt;
        m_full = (lvl == DEPTH);
        e.waddr = 4'(wcnt % DEPTH);
        e.gray  = to_gray(wcnt);
        e.full  = m_full;
        e.af    = (lvl >= THRESH);
        e.ovf   = m_ovf;
        e.level = 5'(lvl);
        sb.push_back(e);
    endtask

    // Let the last pushed entry be checked, then idle the inputs.
    task automatic drain();
        @(posedge clk);
        #2;
        wr_req  = 1'b0;
        ovf_clr = 1'b0;
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare the combinational strobe mid-cycle and registered outputs after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_en", 32'(wr_en), 32'(e.wr_en));
                @(posedge clk);
                #1;
                check("waddr", 32'(waddr), 32'(e.waddr));
                check("wptr_gray", 32'(wptr_gray), 32'(e.gray));
                check("full", 32'(full), 32'(e.full));
                check("almost_full", 32'(almost_full), 32'(e.af));
                check("overflow", 32'(overflow), 32'(e.ovf));
`ifdef ASYNC_FIFO_WR_LEVEL_EN
                check("wr_level", 32'(wr_level), 32'(e.level));
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, 32'(waddr), 32'd0);
        check({tag, "_gray"}, 32'(wptr_gray), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_afull"}, 32'(almost_full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
        check({tag, "_level"}, 32'(wr_level), 32'd0);
`endif
    endtask

    initial begin : driver
        reset_n        = 1'b1;
        wr_req         = 1'b0;
        ovf_clr        = 1'b0;
        rptr_gray_sync = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full with the reader parked at zero.
        repeat (16) step(1'b1, 1'b0, 1'b0);
        // Write attempts while full, then clear overflow.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        // Clear/set collision keeps overflow high.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        // Reader advances one slot, one write refills.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Drain to a lag of three, then stream 40 writes with the reader tracking.
        while (wcnt - rcnt > 3) step(1'b0, 1'b0, 1'b1);
        repeat (40) step(1'b1, 1'b0, 1'b1);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) == 0));
        end
        repeat (5) step(1'b1, 1'b0, 1'b1);
        drain();

        // Asynchronous reset asserted between clock edges mid-burst.
        wr_req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        wr_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wcnt    = 0;
        rcnt    = 0;
        m_full  = 1'b0;
        m_ovf   = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        drain();
        check("post_rst_waddr", 32'(waddr), 32'd1);
        check("post_rst_gray", 32'(wptr_gray), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
